// File: rtl/usb3_cmd_decoder.sv
// EP8 command-frame decoder: parses framed burst-write packets from the slave-FIFO
// down path, verifies the XOR checksum, then replays the payload onto the register bus.
module usb3_cmd_decoder #(
   parameter int          MAX_LEN  = 16,
   parameter int          ADDR_W   = 16,
   parameter int          TIMEOUT  = 1024,
   parameter logic [15:0] HDR_SYNC = 16'hA5A5
) (
   input  logic              clk_100,
   input  logic              reset_,
   input  logic [31:0]       downdata,
   input  logic              downdata_acq,
   output logic              reg_wr_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wr_data,
   output logic              frame_ok,
   output logic              frame_err,
   output logic [2:0]        err_code,
   output logic [15:0]       err_cnt,
   output logic              busy
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] GET_ADDR = 3'd1;
   localparam logic [2:0] GET_DATA = 3'd2;
   localparam logic [2:0] GET_CSUM = 3'd3;
   localparam logic [2:0] COMMIT   = 3'd4;

   localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int         TMO_W     = $clog2(TIMEOUT + 1);
   localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LEN);
   localparam logic [7:0] OP_BURST  = 8'h01;

   logic [2:0]        state;
   logic [7:0]        len;
   logic [ADDR_W-1:0] base;
   logic [31:0]       csum;
   logic [IDX_W-1:0]  data_idx;
   logic [IDX_W-1:0]  cmt_idx;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [31:0]       payload [MAX_LEN];

   logic              hdr_sync;
   logic              len_bad;
   logic              tmo_hit;
   logic              err_fire;
   logic [2:0]        err_val;
   logic [7:0]        len_m1;

   assign hdr_sync = (downdata[31:16] == HDR_SYNC);
   assign len_bad  = (downdata[7:0] == 8'd0) || ({1'b0, downdata[7:0]} > MAX_LEN_9);
   assign tmo_hit  = !downdata_acq && (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign len_m1   = len - 8'd1;
   assign busy     = (state != IDLE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      err_fire = 1'b0;
      err_val  = 3'd0;
      case (state)
         IDLE: begin
            if (downdata_acq && hdr_sync) begin
               if (downdata[15:8] != OP_BURST) begin
                  err_fire = 1'b1;
                  err_val  = 3'd1;
               end else if (len_bad) begin
                  err_fire = 1'b1;
                  err_val  = 3'd2;
               end
            end
         end
         GET_ADDR, GET_DATA: begin
            if (tmo_hit) begin
               err_fire = 1'b1;
               err_val  = 3'd4;
            end
         end
         GET_CSUM: begin
            if (downdata_acq && (downdata != csum)) begin
               err_fire = 1'b1;
               err_val  = 3'd3;
            end else if (tmo_hit) begin
               err_fire = 1'b1;
               err_val  = 3'd4;
            end
         end
         COMMIT: begin
            // Any word arriving mid-commit is dropped and reported as an overrun.
            if (downdata_acq) begin
               err_fire = 1'b1;
               err_val  = 3'd5;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the payload buffer is plain storage with no reset; it is always written before it is read.
   always_ff @(posedge clk_100) begin
      if (state == GET_DATA && downdata_acq) begin
         payload[data_idx] <= downdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         state       <= IDLE;
         len         <= 8'd0;
         base        <= '0;
         csum        <= 32'd0;
         data_idx    <= '0;
         cmt_idx     <= '0;
         tmo_cnt     <= '0;
         reg_wr_en   <= 1'b0;
         reg_addr    <= '0;
         reg_wr_data <= 32'd0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= 3'd0;
         err_cnt     <= 16'd0;
      end else begin
         reg_wr_en <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= err_fire;
         if (err_fire) begin
            err_code <= err_val;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         end

         if (downdata_acq || state == IDLE || state == COMMIT) tmo_cnt <= '0;
         else                                                  tmo_cnt <= tmo_cnt + TMO_W'(1);

         case (state)
            IDLE: begin
               if (downdata_acq && hdr_sync && !err_fire) begin
                  len   <= downdata[7:0];
                  csum  <= downdata;
                  state <= GET_ADDR;
               end
            end
            GET_ADDR: begin
               if (err_fire) begin
                  state <= IDLE;
               end else if (downdata_acq) begin
                  base     <= downdata[ADDR_W-1:0];
                  csum     <= csum ^ downdata;
                  data_idx <= '0;
                  state    <= GET_DATA;
               end
            end
            GET_DATA: begin
               if (err_fire) begin
                  state <= IDLE;
               end else if (downdata_acq) begin
                  csum     <= csum ^ downdata;
                  data_idx <= data_idx + IDX_W'(1);
                  if (8'(data_idx) == len_m1) state <= GET_CSUM;
               end
            end
            GET_CSUM: begin
               if (err_fire) begin
                  state <= IDLE;
               end else if (downdata_acq) begin
                  // First write goes out in the cycle right after the checksum is accepted.
                  reg_wr_en   <= 1'b1;
                  reg_addr    <= base;
                  reg_wr_data <= payload[0];
                  frame_ok    <= (len == 8'd1);
                  cmt_idx     <= IDX_W'(1);
                  state       <= (len == 8'd1) ? IDLE : COMMIT;
               end
            end
            COMMIT: begin
               reg_wr_en   <= 1'b1;
               reg_addr    <= base + ADDR_W'(cmt_idx);
               reg_wr_data <= payload[cmt_idx];
               cmt_idx     <= cmt_idx + IDX_W'(1);
               if (8'(cmt_idx) == len_m1) begin
                  frame_ok <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb3_cmd_decoder.sv
// Directed bench for usb3_cmd_decoder: good/bad frames, header errors, timeout,
// overrun with address wrap, reset during commit and error-counter saturation.
module tb_usb3_cmd_decoder;

   logic        clk_100 = 1'b0;
   logic        reset_;
   logic [31:0] downdata;
   logic        downdata_acq;
   logic        reg_wr_en;
   logic [15:0] reg_addr;
   logic [31:0] reg_wr_data;
   logic        frame_ok;
   logic        frame_err;
   logic [2:0]  err_code;
   logic [15:0] err_cnt;
   logic        busy;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] exp_data [16];

   usb3_cmd_decoder #(.MAX_LEN(16), .ADDR_W(16), .TIMEOUT(1024), .HDR_SYNC(16'hA5A5)) dut (
      .clk_100      (clk_100),
      .reset_       (reset_),
      .downdata     (downdata),
      .downdata_acq (downdata_acq),
      .reg_wr_en    (reg_wr_en),
      .reg_addr     (reg_addr),
      .reg_wr_data  (reg_wr_data),
      .frame_ok     (frame_ok),
      .frame_err    (frame_err),
      .err_code     (err_code),
      .err_cnt      (err_cnt),
      .busy         (busy)
   );

   always #5 clk_100 = ~clk_100;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one word for exactly one rising edge; returns just after that edge.
   task automatic drive(input logic [31:0] w);
      downdata     = w;
      downdata_acq = 1'b1;
      @(posedge clk_100);
      #1;
      downdata_acq = 1'b0;
   endtask

   function automatic logic [31:0] frame_csum(input logic [31:0] hdr, input logic [31:0] addr, input int n);
      logic [31:0] x;
      x = hdr ^ addr;
      for (int i = 0; i < n; i++) x = x ^ exp_data[i];
      return x;
   endfunction

   task automatic send_frame(input logic [31:0] hdr, input logic [31:0] addr, input int n,
                             input logic [31:0] corrupt);
      drive(hdr);
      drive(addr);
      for (int i = 0; i < n; i++) drive(exp_data[i]);
      drive(frame_csum(hdr, addr, n) ^ corrupt);
   endtask

   // Called right after the checksum edge; inj >= 0 injects one word in that commit cycle.
   task automatic check_commit(input logic [15:0] base, input int n, input int inj);
      for (int i = 0; i < n; i++) begin
         if (i == inj) begin
            downdata     = 32'hA5A50102;
            downdata_acq = 1'b1;
         end
         @(negedge clk_100);
         check($sformatf("wr_en[%0d]", i), {31'd0, reg_wr_en}, 32'd1);
         check($sformatf("addr[%0d]", i), {16'd0, reg_addr}, {16'd0, 16'(base + 16'(i))});
         check($sformatf("data[%0d]", i), reg_wr_data, exp_data[i]);
         check($sformatf("frame_ok[%0d]", i), {31'd0, frame_ok}, {31'd0, (i == n - 1)});
         check($sformatf("frame_err[%0d]", i), {31'd0, frame_err}, {31'd0, (inj >= 0 && i == inj + 1)});
         @(posedge clk_100);
         #1;
         downdata_acq = 1'b0;
      end
      @(negedge clk_100);
      check("wr_en_after", {31'd0, reg_wr_en}, 32'd0);
      check("frame_ok_after", {31'd0, frame_ok}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bit found;

      reset_       = 1'b0;
      downdata     = 32'd0;
      downdata_acq = 1'b0;
      #2;
      check("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
      check("rst_addr", {16'd0, reg_addr}, 32'd0);
      check("rst_data", reg_wr_data, 32'd0);
      check("rst_ok", {31'd0, frame_ok}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      check("rst_code", {29'd0, err_code}, 32'd0);
      check("rst_cnt", {16'd0, err_cnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      #20;
      reset_ = 1'b1;
      @(posedge clk_100);
      #1;

      // Non-sync words in IDLE are silently ignored.
      drive(32'h12345678);
      @(negedge clk_100);
      check("nosync_busy", {31'd0, busy}, 32'd0);
      check("nosync_err", {31'd0, frame_err}, 32'd0);
      check("nosync_cnt", {16'd0, err_cnt}, 32'd0);

      // Good two-word frame, words back to back.
      exp_data[0] = 32'h11111111;
      exp_data[1] = 32'h22222222;
      drive(32'hA5A50102);
      check("hdr_busy", {31'd0, busy}, 32'd1);
      drive(32'h00000010);
      drive(32'h11111111);
      drive(32'h22222222);
      drive(32'h96963221);
      check_commit(16'h0010, 2, -1);
      check("good_cnt", {16'd0, err_cnt}, 32'd0);
      check("good_code", {29'd0, err_code}, 32'd0);

      // Bad checksum: no writes, error 3.
      drive(32'hA5A50102);
      drive(32'h00000010);
      drive(32'h11111111);
      drive(32'h22222222);
      drive(32'h96963220);
      @(negedge clk_100);
      check("csum_err", {31'd0, frame_err}, 32'd1);
      check("csum_wr_en", {31'd0, reg_wr_en}, 32'd0);
      check("csum_code", {29'd0, err_code}, 32'd3);
      check("csum_cnt", {16'd0, err_cnt}, 32'd1);
      check("csum_busy", {31'd0, busy}, 32'd0);
      @(negedge clk_100);
      check("csum_err_pulse", {31'd0, frame_err}, 32'd0);
      check("csum_wr_en2", {31'd0, reg_wr_en}, 32'd0);
      send_frame(32'hA5A50102, 32'h00000010, 2, 32'd0);
      check_commit(16'h0010, 2, -1);

      // Header errors.
      drive(32'hA5A50100);
      @(negedge clk_100);
      check("n0_err", {31'd0, frame_err}, 32'd1);
      check("n0_code", {29'd0, err_code}, 32'd2);
      check("n0_cnt", {16'd0, err_cnt}, 32'd2);
      check("n0_busy", {31'd0, busy}, 32'd0);
      drive(32'hA5A50111);
      @(negedge clk_100);
      check("n17_code", {29'd0, err_code}, 32'd2);
      check("n17_cnt", {16'd0, err_cnt}, 32'd3);
      drive(32'hA5A50202);
      @(negedge clk_100);
      check("op_code", {29'd0, err_code}, 32'd1);
      check("op_cnt", {16'd0, err_cnt}, 32'd4);
      check("op_busy", {31'd0, busy}, 32'd0);
      drive(32'hA5A50200);
      @(negedge clk_100);
      check("op_prio_code", {29'd0, err_code}, 32'd1);
      check("op_prio_cnt", {16'd0, err_cnt}, 32'd5);

      // Timeout after header and address.
      drive(32'hA5A50102);
      drive(32'h00000010);
      w = 0;
      found = 1'b0;
      while (!found && w < 1100) begin
         @(negedge clk_100);
         w++;
         if (frame_err) found = 1'b1;
      end
      check("tmo_seen", {31'd0, found}, 32'd1);
      check("tmo_window", {31'd0, (w >= 1024 && w <= 1026)}, 32'd1);
      check("tmo_code", {29'd0, err_code}, 32'd4);
      check("tmo_cnt", {16'd0, err_cnt}, 32'd6);
      check("tmo_busy", {31'd0, busy}, 32'd0);
      send_frame(32'hA5A50102, 32'h00000010, 2, 32'd0);
      check_commit(16'h0010, 2, -1);

      // Full-length frame with address wrap and one overrun word mid-commit.
      for (int i = 0; i < 16; i++) exp_data[i] = 32'h0BAD0000 + 32'(i * 32'h00010111);
      send_frame(32'hA5A50110, 32'h0000FFFE, 16, 32'd0);
      check_commit(16'hFFFE, 16, 5);
      check("ovr_code", {29'd0, err_code}, 32'd5);
      check("ovr_cnt", {16'd0, err_cnt}, 32'd7);
      check("ovr_busy", {31'd0, busy}, 32'd0);

      // Reset during commit stops writes immediately.
      exp_data[0] = 32'hCAFE0000;
      exp_data[1] = 32'hCAFE0001;
      exp_data[2] = 32'hCAFE0002;
      exp_data[3] = 32'hCAFE0003;
      send_frame(32'hA5A50104, 32'h00000100, 4, 32'd0);
      @(negedge clk_100);
      check("rstc_wr_en_pre", {31'd0, reg_wr_en}, 32'd1);
      #2;
      reset_ = 1'b0;
      #1;
      check("rstc_wr_en", {31'd0, reg_wr_en}, 32'd0);
      check("rstc_addr", {16'd0, reg_addr}, 32'd0);
      check("rstc_data", reg_wr_data, 32'd0);
      check("rstc_busy", {31'd0, busy}, 32'd0);
      check("rstc_cnt", {16'd0, err_cnt}, 32'd0);
      repeat (3) @(posedge clk_100);
      @(negedge clk_100);
      reset_ = 1'b1;
      exp_data[0] = 32'h11111111;
      exp_data[1] = 32'h22222222;
      send_frame(32'hA5A50102, 32'h00000010, 2, 32'd0);
      check_commit(16'h0010, 2, -1);

      // Error counter saturation.
      force dut.err_cnt = 16'hFFFE;
      @(posedge clk_100);
      #1;
      release dut.err_cnt;
      drive(32'hA5A50202);
      @(negedge clk_100);
      check("sat_err", {31'd0, frame_err}, 32'd1);
      check("sat_cnt1", {16'd0, err_cnt}, 32'h0000FFFF);
      drive(32'hA5A50202);
      @(negedge clk_100);
      check("sat_cnt2", {16'd0, err_cnt}, 32'h0000FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/usb3_cmd_decoder.md
Name: usb3_cmd_decoder

Overview:
Downstream consumer of the FX3 slave-FIFO interface's EP8 command path. Takes the registered down-data word stream (downdata + downdata_acq) and parses framed command packets. Payload is buffered until the frame checksum is verified, then committed as a burst of register writes to the FPGA control register bus. Reports frame completion and errors for status readback over EP6.

Parameters:
MAX_LEN, 16, maximum payload words per frame; sets payload buffer depth
ADDR_W, 16, register bus address width
TIMEOUT, 1024, idle clk_100 cycles allowed between words inside a frame before abort
HDR_SYNC, 16'hA5A5, required value of header bits [31:16]

Ports:
clk_100  in  1  system clock, 100 MHz; single clock domain
reset_  in  1  asynchronous active-low reset
downdata  in  32  command word from the slave-FIFO interface
downdata_acq  in  1  downdata valid this cycle; no backpressure toward the source
reg_wr_en  out  1  register write strobe, one write per cycle
reg_addr  out  ADDR_W  register write address
reg_wr_data  out  32  register write data
frame_ok  out  1  one-cycle pulse on the last write of a committed frame
frame_err  out  1  one-cycle pulse when a frame is aborted
err_code  out  3  last error: 0 none, 1 bad opcode, 2 bad length, 3 checksum, 4 timeout, 5 overrun
err_cnt  out  16  saturating count of frame errors
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_=0): state IDLE. reg_wr_en, frame_ok, frame_err, busy = 0. reg_addr, reg_wr_data, err_code, err_cnt = 0. Buffer contents are don't-care.
- Frame format, one word per downdata_acq cycle:
  - Header: [31:16]=HDR_SYNC, [15:8]=opcode, [7:0]=N.
  - Address word: low ADDR_W bits = base address.
  - N data words.
  - Checksum word: XOR of the header, the address word and all N data words.
- Only opcode 8'h01 (burst write) is legal. N must satisfy 1 <= N <= MAX_LEN.
- States and transitions:
  - IDLE: on acq with [31:16]==HDR_SYNC, latch opcode/N, seed the XOR with the header, go to GET_ADDR. If opcode != 01, error 1. Else if N==0 or N>MAX_LEN, error 2 (opcode check has priority). Acq words without sync are discarded silently with no error.
  - GET_ADDR: on acq, latch base, XOR in, clear index, go to GET_DATA.
  - GET_DATA: on acq, buf[index]=word, XOR in, index++. After the N-th word go to GET_CSUM.
  - GET_CSUM: on acq, compare the word to the running XOR. Match: go to COMMIT. Mismatch: error 3.
  - COMMIT: one buffered word per cycle, no gaps; go to IDLE after word N-1.
- Commit timing: checksum word accepted on edge k. reg_wr_en is high in cycles k+1..k+N. Cycle k+1+i carries reg_addr=base+i (modulo 2^ADDR_W, wraps) and reg_wr_data=buf[i]. frame_ok is high in cycle k+N only.
- reg_addr and reg_wr_data hold their last values when reg_wr_en=0.
- Error handling: the state returns to IDLE on the next edge. frame_err pulses 1 cycle. err_code is updated. err_cnt increments and saturates at 16'hFFFF. No register writes are issued for an aborted frame. The word that caused an error is not re-parsed as a header.
- Timeout: in GET_ADDR, GET_DATA or GET_CSUM, a counter of consecutive cycles without acq is kept and cleared on every acq. When it reaches TIMEOUT, error 4.
- Overrun: acq during COMMIT means the word is dropped. The commit still completes and frame_ok still pulses. err_code=5, err_cnt increments, frame_err pulses one cycle after the overrun word. Several overrun words in one commit count once per word.
- If frame_ok and an overrun frame_err fall in the same cycle, both assert.
- Reset mid-COMMIT: writes stop immediately and the remaining words are lost.
- busy is combinational from state.

Test Plan:
- Good frame: acq words A5A50102, 00000010, 11111111, 22222222, 96963221 on consecutive cycles -> reg_wr_en high 2 cycles, (0010,11111111) then (0011,22222222); frame_ok on the second write; err_cnt=0.
- Same frame with checksum 96963220 -> no reg_wr_en, frame_err 1 cycle, err_code=3, err_cnt=1. A following good frame still commits.
- Header A5A50100 (N=0) -> err_code=2. Header A5A50111 (N=17, MAX_LEN=16) -> err_code=2. Header A5A50202 -> err_code=1. Non-sync words (e.g. 12345678) in IDLE -> no error, busy stays 0.
- Header and address, then no acq for 1024 cycles -> frame_err, err_code=4, IDLE. A later good frame commits normally.
- N=16, base FFFE: addresses FFFE, FFFF, 0000..000D in 16 back-to-back cycles. One acq injected mid-commit -> all 16 writes done, frame_ok, err_code=5.
- Assert reset_ low for 3 cycles during COMMIT -> outputs go to 0 asynchronously. After release, the next frame decodes correctly. err_cnt saturation checked via a forced value near FFFF plus a bad frame -> stays FFFF.
